memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 40 ++++
 rtl/memory_arbiter.sv | 132 +++++++++++++
 tb/tb_memory_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Shared-RAM arbiter bundle: instruction port, data port and RAM port.
// slave is the arbiter's view; master is the client/RAM environment view.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr,
    input  dREN, dWEN, daddr, dstore,
    input  ramload, ramstate,
    output iwait, iload,
    output dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr,
    output dREN, dWEN, daddr, dstore,
    output ramload, ramstate,
    input  iwait, iload,
    input  dwait, dload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Instruction/data arbiter onto one shared RAM port with alternating
// tie-break, per-grant timeout abort and cancel when a client drops.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input  logic            CLK,
  input  logic            RST,
  memory_arbiter_if.slave bus,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } state_t;

  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  localparam logic [7:0] LIMIT  = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic       last;
  logic       last_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic       dreq;
  logic       done;
  logic       expire;
  logic       abort;

  assign dreq   = bus.dREN | bus.dWEN;
  assign done   = bus.ramstate == ACCESS;
  assign expire = (bus.ramstate == ERROR) || (cnt == LIMIT);

  // last=1 means data was served last, so a tie goes to instruction
  function automatic state_t arb(
    input logic i,
    input logic d,
    input logic l
  );
    state_t s;
    s = IDLE;
    unique case (1'b1)
      (i && d):  s = l ? ISERV : DSERV;
      (d && !i): s = DSERV;
      (i && !d): s = ISERV;
      default:   s = IDLE;
    endcase
    return s;
  endfunction

  always_comb begin
    state_nx     = state;
    last_nx      = last;
    abort        = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = bus.iREN;
    bus.dwait    = dreq;
    bus.iload    = '0;
    bus.dload    = '0;
    unique case (state)
      IDLE: begin
        state_nx = arb(bus.iREN, dreq, last);
      end
      DSERV: begin
        if (!dreq) begin
          state_nx = arb(bus.iREN, 1'b0, last);
        end else begin
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = ~bus.dWEN;
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          if (done || expire) begin
            bus.dwait = 1'b0;
            bus.dload = done ? bus.ramload : ERRWORD;
            abort     = ~done;
            last_nx   = 1'b1;
            state_nx  = bus.iREN ? ISERV : IDLE;
          end
        end
      end
      ISERV: begin
        if (!bus.iREN) begin
          state_nx = arb(1'b0, dreq, last);
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (done || expire) begin
            bus.iwait = 1'b0;
            bus.iload = done ? bus.ramload : ERRWORD;
            abort     = ~done;
            last_nx   = 1'b0;
            state_nx  = dreq ? DSERV : IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state) begin
      cnt_nx = '0;
    end else if (state != IDLE && !done && cnt != 8'hFF) begin
      cnt_nx = cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      last  <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      err   <= abort;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed scenarios then random
// traffic, checked against a transaction-level ownership model.
module tb_memory_arbiter;

  localparam int          TIMEOUT = 4;
  localparam logic [31:0] ERRWORD = 32'hBAD1BAD1;
  localparam logic [1:0]  FREE    = 2'd0;
  localparam logic [1:0]  BUSY    = 2'd1;
  localparam logic [1:0]  ACCESS  = 2'd2;
  localparam logic [1:0]  ERROR   = 2'd3;

  typedef struct packed {
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic        i_wait;
    logic [31:0] i_load;
    logic        d_wait;
    logic [31:0] d_load;
    logic        err;
  } obs_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic err;

  memory_arbiter_if bus ();

  memory_arbiter #(
    .TIMEOUT(TIMEOUT),
    .ERRWORD(ERRWORD)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus),
    .err(err)
  );

  always #5 CLK = ~CLK;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    fails  = 0;

  bit          s_ir;
  bit          s_dr;
  bit          s_dw;
  logic [31:0] s_ia;
  logic [31:0] s_da;
  logic [31:0] s_ds;
  logic [1:0]  s_rs;
  logic [31:0] s_rl;

  // model: owner 0=none 1=data 2=instr; age=grant cycles already spent
  int m_owner  = 0;
  int m_age    = 0;
  bit m_last_d = 1'b0;
  bit m_err    = 1'b0;

  function automatic int pick(input bit i, input bit d);
    if (i && d) return m_last_d ? 2 : 1;
    if (d) return 1;
    if (i) return 2;
    return 0;
  endfunction

  task automatic model(input bit r, output obs_t e);
    bit          dq;
    bit          mine;
    bit          fin;
    bit          ab;
    int          nown;
    int          nage;
    bit          nlast;
    logic [31:0] word;
    dq     = s_dr | s_dw;
    e      = '0;
    e.i_wait = s_ir;
    e.d_wait = dq;
    nown   = m_owner;
    nage   = m_age + 1;
    nlast  = m_last_d;
    ab     = 1'b0;
    if (r) begin
      nown  = 0;
      nage  = 0;
      nlast = 1'b0;
    end else begin
      e.err = m_err;
      if (m_owner == 0) begin
        nown = pick(s_ir, dq);
        nage = 0;
      end else begin
        mine = (m_owner == 1) ? dq : s_ir;
        if (!mine) begin
          nown = (m_owner == 1) ? pick(s_ir, 1'b0) : pick(1'b0, dq);
          nage = 0;
        end else begin
          if (m_owner == 1) begin
            e.ram_wen   = s_dw;
            e.ram_ren   = !s_dw;
            e.ram_addr  = s_da;
            e.ram_store = s_ds;
          end else begin
            e.ram_ren  = 1'b1;
            e.ram_addr = s_ia;
          end
          fin = (s_rs == ACCESS);
          ab  = !fin && (s_rs == ERROR || m_age + 1 == TIMEOUT);
          if (fin || ab) begin
            word = fin ? s_rl : ERRWORD;
            nage = 0;
            if (m_owner == 1) begin
              e.d_wait = 1'b0;
              e.d_load = word;
              nlast    = 1'b1;
              nown     = s_ir ? 2 : 0;
            end else begin
              e.i_wait = 1'b0;
              e.i_load = word;
              nlast    = 1'b0;
              nown     = dq ? 1 : 0;
            end
          end
        end
      end
    end
    m_owner  = nown;
    m_age    = nage;
    m_last_d = nlast;
    m_err    = ab;
  endtask

  task automatic step(input string tag, input bit rn, input bit mr);
    obs_t e;
    @(posedge CLK);
    #1;
    RST          = rn;
    bus.iREN     = s_ir;
    bus.iaddr    = s_ia;
    bus.dREN     = s_dr;
    bus.dWEN     = s_dw;
    bus.daddr    = s_da;
    bus.dstore   = s_ds;
    bus.ramstate = s_rs;
    bus.ramload  = s_rl;
    model(rn || mr, e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (mr) begin
      #2;
      RST = 1'b1;
    end
  endtask

  task automatic go(
    input string       tag,
    input bit          ir,
    input bit          dr,
    input bit          dw,
    input logic [31:0] ia,
    input logic [31:0] da,
    input logic [31:0] ds,
    input logic [1:0]  rs,
    input logic [31:0] rl,
    input bit          rn,
    input bit          mr
  );
    s_ir = ir;
    s_dr = dr;
    s_dw = dw;
    s_ia = ia;
    s_da = da;
    s_ds = ds;
    s_rs = rs;
    s_rl = rl;
    step(tag, rn, mr);
  endtask

  obs_t  mon_e;
  obs_t  mon_g;
  string mon_t;

  initial begin
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        mon_g.ram_ren   = bus.ramREN;
        mon_g.ram_wen   = bus.ramWEN;
        mon_g.ram_addr  = bus.ramaddr;
        mon_g.ram_store = bus.ramstore;
        mon_g.i_wait    = bus.iwait;
        mon_g.i_load    = bus.iload;
        mon_g.d_wait    = bus.dwait;
        mon_g.d_load    = bus.dload;
        mon_g.err       = err;
        checks++;
        if (mon_g !== mon_e) begin
          fails++;
          $display("FAIL %s t=%0t: got %h required %h", mon_t, $time,
                   mon_g, mon_e);
        end
      end
    end
  end

  bit ihold;
  bit dhold;
  bit mid;
  bit mid_prev;
  int kind;
  int r;

  initial begin
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramstate = FREE;
    bus.ramload  = '0;

    go("reset", 0, 0, 0, 0, 0, 0, FREE, 0, 1, 0);
    go("reset_req", 1, 1, 0, 32'h10, 32'h20, 0, BUSY, 32'h5, 1, 0);

    go("tie_idle", 1, 1, 0, 32'h100, 32'h200, 0, BUSY, 32'h1, 0, 0);
    go("tie_d_busy1", 1, 1, 0, 32'h100, 32'h200, 0, BUSY, 32'h2, 0, 0);
    go("tie_d_busy2", 1, 1, 0, 32'h100, 32'h200, 0, BUSY, 32'h3, 0, 0);
    go("tie_d_access", 1, 1, 0, 32'h100, 32'h200, 0, ACCESS, 32'hD00D, 0, 0);
    go("tie_i_busy", 1, 0, 0, 32'h100, 0, 0, BUSY, 32'h4, 0, 0);
    go("tie_i_access", 1, 0, 0, 32'h100, 0, 0, ACCESS, 32'h1CE, 0, 0);
    go("idle", 0, 0, 0, 0, 0, 0, FREE, 0, 0, 0);

    for (int k = 0; k < 17; k++) begin
      go("fair", 1, 1, 0, 32'h1000 + k, 32'h2000 + k, 0,
         (k % 2 == 1) ? ACCESS : BUSY, 32'hF000 + k, 0, 0);
    end
    go("idle", 0, 0, 0, 0, 0, 0, FREE, 0, 0, 0);

    go("write_idle", 0, 0, 1, 0, 32'h40, 32'hCAFEF00D, BUSY, 32'h7, 0, 0);
    go("write_busy", 0, 0, 1, 0, 32'h40, 32'hCAFEF00D, BUSY, 32'h7, 0, 0);
    go("write_access", 0, 0, 1, 0, 32'h40, 32'hCAFEF00D, ACCESS, 32'h7, 0, 0);
    go("rw_idle", 0, 1, 1, 0, 32'h44, 32'h1234, FREE, 32'h8, 0, 0);
    go("rw_access", 0, 1, 1, 0, 32'h44, 32'h1234, ACCESS, 32'h8, 0, 0);
    go("idle", 0, 0, 0, 0, 0, 0, FREE, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      go("timeout", 1, 0, 0, 32'h300, 0, 0, BUSY, 32'h9, 0, 0);
    end
    go("timeout_err", 0, 0, 0, 0, 0, 0, FREE, 0, 0, 0);
    go("idle", 0, 0, 0, 0, 0, 0, FREE, 0, 0, 0);

    go("error_idle", 0, 1, 0, 0, 32'h500, 0, BUSY, 32'hA, 0, 0);
    go("error_abort", 0, 1, 0, 0, 32'h500, 0, ERROR, 32'hA, 0, 0);
    go("error_pulse", 0, 0, 0, 0, 0, 0, FREE, 0, 0, 0);
    go("idle", 0, 0, 0, 0, 0, 0, FREE, 0, 0, 0);

    go("cancel_idle", 0, 1, 0, 0, 32'h600, 0, BUSY, 32'hB, 0, 0);
    go("cancel_busy", 0, 1, 0, 0, 32'h600, 0, BUSY, 32'hB, 0, 0);
    go("cancel_drop", 0, 0, 0, 0, 32'h600, 0, BUSY, 32'hB, 0, 0);
    go("cancel_after", 0, 0, 0, 0, 0, 0, BUSY, 0, 0, 0);

    go("ar_idle", 1, 0, 0, 32'h700, 0, 0, BUSY, 32'hC, 0, 0);
    go("ar_busy", 1, 0, 0, 32'h700, 0, 0, BUSY, 32'hC, 0, 0);
    go("ar_mid", 1, 0, 0, 32'h700, 0, 0, BUSY, 32'hC, 0, 1);
    go("ar_hold", 1, 1, 0, 32'h700, 32'h800, 0, BUSY, 32'hC, 1, 0);
    go("ar_tie", 1, 1, 0, 32'h700, 32'h800, 0, BUSY, 32'hC, 0, 0);
    go("ar_tie_d", 1, 1, 0, 32'h700, 32'h800, 0, ACCESS, 32'hD, 0, 0);
    go("ar_tie_i", 1, 0, 0, 32'h700, 0, 0, ACCESS, 32'hE, 0, 0);
    go("idle", 0, 0, 0, 0, 0, 0, FREE, 0, 0, 0);

    ihold    = 1'b0;
    dhold    = 1'b0;
    mid_prev = 1'b0;
    for (int n = 0; n < 800; n++) begin
      ihold = ihold ? ($urandom_range(15) != 0) : ($urandom_range(2) == 0);
      dhold = dhold ? ($urandom_range(15) != 0) : ($urandom_range(2) == 0);
      kind  = $urandom_range(2);
      s_ir  = ihold;
      s_dr  = dhold && (kind != 1);
      s_dw  = dhold && (kind != 0);
      s_ia  = $urandom;
      s_da  = $urandom;
      s_ds  = $urandom;
      s_rl  = $urandom;
      r     = $urandom_range(9);
      s_rs  = (r == 0) ? FREE : (r <= 5) ? BUSY : (r <= 8) ? ACCESS : ERROR;
      mid   = ($urandom_range(199) == 0);
      step("random", mid_prev, mid);
      mid_prev = mid;
    end
    go("final_idle", 0, 0, 0, 0, 0, 0, FREE, 0, 0, 0);

    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
